// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encodings and CRC-8 constants for the config chain loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial CRC-8 step, MSB-first, polynomial x^8+x^2+x+1.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host word port, status and chain head/tail signals of the config loader
interface prog_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              chain_tail;
  logic              prog_out;
  logic              prog_en;
  logic              busy;
  logic              done;
  logic              error;
  logic [7:0]        crc_value;

  modport master (
    output start, data_in, data_valid, chain_tail,
    input  data_ready, prog_out, prog_en, busy, done, error, crc_value
  );

  modport slave (
    input  start, data_in, data_valid, chain_tail,
    output data_ready, prog_out, prog_en, busy, done, error, crc_value
  );
endinterface

// File: rtl/prog_loader_crc8.sv
// rtl/prog_loader_crc8.sv - serial CRC-8 accumulator with synchronous clear and bit enable
module crc8_serial
  import prog_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC8_INIT;
    end else if (en) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC8_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serialises bitstream words into the config chain, then rotates it once to CRC-verify
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic          prog_clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int SCNT_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] ALL_WORDS  = WCNT_W'(NWORDS);
  localparam logic [SCNT_W-1:0] WORD_REST  = SCNT_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [SCNT_W-1:0]   sr_cnt_q, sr_cnt_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                prog_en_q, prog_en_d;
  logic                prog_out_q, prog_out_d;
  logic [7:0]          crc_value_q, crc_value_d;

  logic [7:0]          load_crc;
  logic [7:0]          verify_crc;
  logic                start_ok;
  logic                accept;
  logic                last_shift;

  assign start_ok   = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  // sr_cnt counts bits still waiting behind the one currently on prog_out, so a
  // zero count lets the next word land exactly as the last bit leaves.
  assign bus.data_ready = (state_q == ST_LOAD) && (sr_cnt_q == '0) && (words_q != ALL_WORDS);
  assign accept     = bus.data_valid && bus.data_ready;
  assign last_shift = prog_en_q && (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sr_cnt_d    = sr_cnt_q;
    words_d     = words_q;
    bit_cnt_d   = bit_cnt_q;
    prog_en_d   = 1'b0;
    prog_out_d  = prog_out_q;
    crc_value_d = crc_value_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) begin
          state_d     = ST_LOAD;
          sr_cnt_d    = '0;
          words_d     = '0;
          bit_cnt_d   = '0;
          prog_out_d  = 1'b0;
          crc_value_d = 8'h00;
        end
      end

      ST_LOAD: begin
        if (prog_en_q) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (last_shift) begin
          state_d     = ST_VERIFY;
          bit_cnt_d   = '0;
          sr_cnt_d    = '0;
          prog_en_d   = 1'b1;
          crc_value_d = crc8_step(load_crc, prog_out_q);
        end else if (sr_cnt_q != '0) begin
          prog_en_d  = 1'b1;
          prog_out_d = sr_q[WORD_W-1];
          sr_d       = sr_q << 1;
          sr_cnt_d   = sr_cnt_q - 1'b1;
        end else if (accept) begin
          prog_en_d  = 1'b1;
          prog_out_d = bus.data_in[WORD_W-1];
          sr_d       = bus.data_in << 1;
          sr_cnt_d   = WORD_REST;
          words_d    = words_q + 1'b1;
        end
      end

      ST_VERIFY: begin
        prog_en_d = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_shift) begin
          prog_en_d = 1'b0;
          bit_cnt_d = bit_cnt_q;
          state_d   = (crc8_step(verify_crc, bus.chain_tail) == crc_value_q) ? ST_DONE : ST_ERROR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      words_q     <= '0;
      bit_cnt_q   <= '0;
      prog_en_q   <= 1'b0;
      prog_out_q  <= 1'b0;
      crc_value_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sr_cnt_q    <= sr_cnt_d;
      words_q     <= words_d;
      bit_cnt_q   <= bit_cnt_d;
      prog_en_q   <= prog_en_d;
      prog_out_q  <= prog_out_d;
      crc_value_q <= crc_value_d;
    end
  end

  crc8_serial u_load_crc (
    .clk    (prog_clk),
    .rst    (rst),
    .clr    (start_ok),
    .en     ((state_q == ST_LOAD) && prog_en_q),
    .bit_in (prog_out_q),
    .crc    (load_crc)
  );

  crc8_serial u_verify_crc (
    .clk    (prog_clk),
    .rst    (rst),
    .clr    (start_ok),
    .en     ((state_q == ST_VERIFY) && prog_en_q),
    .bit_in (bus.chain_tail),
    .crc    (verify_crc)
  );

  // During verify the tail feeds straight back to the head so one rotation restores the chain.
  assign bus.prog_out  = (state_q == ST_VERIFY) ? bus.chain_tail : prog_out_q;
  assign bus.prog_en   = prog_en_q;
  assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.error     = (state_q == ST_ERROR);
  assign bus.crc_value = crc_value_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader with shift-chain models of 8, 12 and 32 bits
module tb_prog_loader;

  logic prog_clk = 1'b0;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  always #5 prog_clk = ~prog_clk;

  prog_loader_if #(.WORD_W(8)) if0 ();
  prog_loader_if #(.WORD_W(8)) if1 ();
  prog_loader_if #(.WORD_W(8)) if2 ();

  prog_loader #(.CHAIN_LEN(8),  .WORD_W(8)) dut0 (.prog_clk(prog_clk), .rst(rst), .bus(if0));
  prog_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut1 (.prog_clk(prog_clk), .rst(rst), .bus(if1));
  prog_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut2 (.prog_clk(prog_clk), .rst(rst), .bus(if2));

  logic       start_r [3];
  logic       dv_r    [3];
  logic       f0_r    [3];
  logic [7:0] din_r   [3];

  logic [7:0]  ch0;
  logic [11:0] ch1;
  logic [31:0] ch2;

  assign if0.start = start_r[0]; assign if0.data_valid = dv_r[0]; assign if0.data_in = din_r[0];
  assign if1.start = start_r[1]; assign if1.data_valid = dv_r[1]; assign if1.data_in = din_r[1];
  assign if2.start = start_r[2]; assign if2.data_valid = dv_r[2]; assign if2.data_in = din_r[2];
  assign if0.chain_tail = f0_r[0] ? 1'b0 : ch0[7];
  assign if1.chain_tail = f0_r[1] ? 1'b0 : ch1[11];
  assign if2.chain_tail = f0_r[2] ? 1'b0 : ch2[31];

  always @(posedge prog_clk) if (if0.prog_en) ch0 <= {ch0[6:0],  if0.prog_out};
  always @(posedge prog_clk) if (if1.prog_en) ch1 <= {ch1[10:0], if1.prog_out};
  always @(posedge prog_clk) if (if2.prog_en) ch2 <= {ch2[30:0], if2.prog_out};

  logic       pe [3], po [3], rdy [3], bsy [3], dn [3], er [3];
  logic [7:0] crcv [3];

  assign pe[0] = if0.prog_en;  assign po[0] = if0.prog_out; assign rdy[0] = if0.data_ready;
  assign bsy[0] = if0.busy;    assign dn[0] = if0.done;     assign er[0] = if0.error;
  assign crcv[0] = if0.crc_value;
  assign pe[1] = if1.prog_en;  assign po[1] = if1.prog_out; assign rdy[1] = if1.data_ready;
  assign bsy[1] = if1.busy;    assign dn[1] = if1.done;     assign er[1] = if1.error;
  assign crcv[1] = if1.crc_value;
  assign pe[2] = if2.prog_en;  assign po[2] = if2.prog_out; assign rdy[2] = if2.data_ready;
  assign bsy[2] = if2.busy;    assign dn[2] = if2.done;     assign er[2] = if2.error;
  assign crcv[2] = if2.crc_value;

  logic [7:0]  words [8];
  int          r_load, r_ver, r_bub, r_acc;
  logic [63:0] r_bits;

  function automatic logic [7:0] ref_crc(input logic [63:0] v, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ v[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Starts instance k, streams nw words (optionally pausing for 3 ready cycles after
  // stall_after words) and records bit traffic until done/error or the cycle budget runs out.
  task automatic run(input int k, input int n, input int nw, input int stall_after, input bit poke);
    int idx;
    int stall_rem;
    bit fin;
    idx = 0; stall_rem = 3; fin = 1'b0;
    r_load = 0; r_ver = 0; r_bub = 0; r_acc = 0; r_bits = '0;
    @(negedge prog_clk); start_r[k] = 1'b1;
    @(negedge prog_clk); start_r[k] = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (pe[k]) begin
        if (r_load < n) begin
          r_bits = {r_bits[62:0], po[k]};
          r_load++;
        end else begin
          r_ver++;
        end
      end else if (bsy[k]) begin
        r_bub++;
      end
      if (dn[k] || er[k]) begin
        fin = 1'b1;
      end else begin
        start_r[k] = poke && ((r_load == 5 && r_ver == 0) || r_ver == 3);
        dv_r[k]    = (idx < nw);
        din_r[k]   = words[idx];
        if (dv_r[k] && rdy[k] && idx == stall_after && stall_rem > 0) begin
          dv_r[k] = 1'b0;
          stall_rem--;
        end
        if (dv_r[k] && rdy[k]) begin
          idx++;
          r_acc++;
        end
        @(negedge prog_clk);
      end
    end
    start_r[k] = 1'b0;
    dv_r[k]    = 1'b0;
    total_cnt++;
    if (fin !== 1'b1) $display("FAIL run_timeout inst %0d got finished=%0b want 1", k, fin);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_r[k] = 1'b0; dv_r[k] = 1'b0; f0_r[k] = 1'b0; din_r[k] = 8'h00;
    end
    repeat (2) @(negedge prog_clk);
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (pe[k]   !== 1'b0)  $display("FAIL rst_prog_en[%0d] got %b want 0", k, pe[k]);   else pass_cnt++;
      total_cnt++; if (po[k]   !== 1'b0)  $display("FAIL rst_prog_out[%0d] got %b want 0", k, po[k]);  else pass_cnt++;
      total_cnt++; if (rdy[k]  !== 1'b0)  $display("FAIL rst_ready[%0d] got %b want 0", k, rdy[k]);    else pass_cnt++;
      total_cnt++; if (bsy[k]  !== 1'b0)  $display("FAIL rst_busy[%0d] got %b want 0", k, bsy[k]);     else pass_cnt++;
      total_cnt++; if (dn[k]   !== 1'b0)  $display("FAIL rst_done[%0d] got %b want 0", k, dn[k]);      else pass_cnt++;
      total_cnt++; if (er[k]   !== 1'b0)  $display("FAIL rst_error[%0d] got %b want 0", k, er[k]);     else pass_cnt++;
      total_cnt++; if (crcv[k] !== 8'h00) $display("FAIL rst_crc[%0d] got %h want 00", k, crcv[k]);    else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge prog_clk);
  endtask

  task automatic test_single_word();
    words[0] = 8'hA5;
    run(0, 8, 1, -1, 1'b0);
    total_cnt++; if (r_load !== 8)            $display("FAIL t1_load_shifts got %0d want 8", r_load);    else pass_cnt++;
    total_cnt++; if (r_bub !== 1)             $display("FAIL t1_bubbles got %0d want 1", r_bub);         else pass_cnt++;
    total_cnt++; if (r_bits[7:0] !== 8'hA5)   $display("FAIL t1_bits got %h want a5", r_bits[7:0]);      else pass_cnt++;
    total_cnt++; if (crcv[0] !== 8'h72)       $display("FAIL t1_crc got %h want 72", crcv[0]);           else pass_cnt++;
    total_cnt++; if (r_ver !== 8)             $display("FAIL t1_verify_shifts got %0d want 8", r_ver);   else pass_cnt++;
    total_cnt++; if (dn[0] !== 1'b1)          $display("FAIL t1_done got %b want 1", dn[0]);             else pass_cnt++;
    total_cnt++; if (er[0] !== 1'b0)          $display("FAIL t1_error got %b want 0", er[0]);            else pass_cnt++;
    total_cnt++; if (ch0[3:0] !== 4'h5)       $display("FAIL t1_head_sel got %h want 5", ch0[3:0]);      else pass_cnt++;
    total_cnt++; if (ch0[7:4] !== 4'hA)       $display("FAIL t1_tail_sel got %h want a", ch0[7:4]);      else pass_cnt++;
    total_cnt++; if (r_acc !== 1)             $display("FAIL t1_words got %0d want 1", r_acc);           else pass_cnt++;
  endtask

  task automatic test_partial_word();
    words[0] = 8'hAB; words[1] = 8'hCD;
    run(1, 12, 2, -1, 1'b0);
    total_cnt++; if (r_load !== 12)              $display("FAIL t2_load_shifts got %0d want 12", r_load);   else pass_cnt++;
    total_cnt++; if (r_ver !== 12)               $display("FAIL t2_verify_shifts got %0d want 12", r_ver);  else pass_cnt++;
    total_cnt++; if (r_acc !== 2)                $display("FAIL t2_words got %0d want 2", r_acc);           else pass_cnt++;
    total_cnt++; if (r_bits[11:0] !== 12'hABC)   $display("FAIL t2_bits got %h want abc", r_bits[11:0]);    else pass_cnt++;
    total_cnt++; if (ch1 !== 12'hABC)            $display("FAIL t2_chain got %h want abc", ch1);            else pass_cnt++;
    total_cnt++; if (crcv[1] !== ref_crc(64'hABC, 12))
      $display("FAIL t2_crc got %h want %h", crcv[1], ref_crc(64'hABC, 12)); else pass_cnt++;
    total_cnt++; if (dn[1] !== 1'b1)             $display("FAIL t2_done got %b want 1", dn[1]);             else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [31:0] ref_chain;
    words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56; words[3] = 8'h78;
    run(2, 32, 4, -1, 1'b0);
    ref_chain = ch2;
    total_cnt++; if (r_bub !== 1)               $display("FAIL t3_nostall_bubbles got %0d want 1", r_bub);  else pass_cnt++;
    total_cnt++; if (ch2 !== 32'h12345678)      $display("FAIL t3_nostall_chain got %h want 12345678", ch2); else pass_cnt++;
    run(2, 32, 4, 2, 1'b0);
    total_cnt++; if (r_bub !== 4)               $display("FAIL t3_stall_bubbles got %0d want 4", r_bub);    else pass_cnt++;
    total_cnt++; if (r_load !== 32)             $display("FAIL t3_load_shifts got %0d want 32", r_load);   else pass_cnt++;
    total_cnt++; if (r_ver !== 32)              $display("FAIL t3_verify_shifts got %0d want 32", r_ver);  else pass_cnt++;
    total_cnt++; if (ch2 !== ref_chain)         $display("FAIL t3_chain_vs_nostall got %h want %h", ch2, ref_chain); else pass_cnt++;
    total_cnt++; if (crcv[2] !== ref_crc(64'h12345678, 32))
      $display("FAIL t3_crc got %h want %h", crcv[2], ref_crc(64'h12345678, 32)); else pass_cnt++;
    total_cnt++; if (dn[2] !== 1'b1)            $display("FAIL t3_done got %b want 1", dn[2]);             else pass_cnt++;
  endtask

  task automatic test_verify_error();
    words[0] = 8'hA5;
    f0_r[0]  = 1'b1;
    run(0, 8, 1, -1, 1'b0);
    f0_r[0]  = 1'b0;
    total_cnt++; if (er[0] !== 1'b1)    $display("FAIL t4_error got %b want 1", er[0]);    else pass_cnt++;
    total_cnt++; if (dn[0] !== 1'b0)    $display("FAIL t4_done got %b want 0", dn[0]);     else pass_cnt++;
    total_cnt++; if (bsy[0] !== 1'b0)   $display("FAIL t4_busy got %b want 0", bsy[0]);    else pass_cnt++;
    total_cnt++; if (crcv[0] !== 8'h72) $display("FAIL t4_crc got %h want 72", crcv[0]);   else pass_cnt++;
  endtask

  task automatic test_rst_mid_load();
    @(negedge prog_clk); start_r[0] = 1'b1;
    @(negedge prog_clk); start_r[0] = 1'b0; dv_r[0] = 1'b1; din_r[0] = 8'hFF;
    @(negedge prog_clk); dv_r[0] = 1'b0;
    repeat (3) @(negedge prog_clk);
    total_cnt++; if (pe[0] !== 1'b1)  $display("FAIL t5_pre_prog_en got %b want 1", pe[0]); else pass_cnt++;
    total_cnt++; if (bsy[0] !== 1'b1) $display("FAIL t5_pre_busy got %b want 1", bsy[0]);   else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (pe[0] !== 1'b0)  $display("FAIL t5_rst_prog_en got %b want 0", pe[0]); else pass_cnt++;
    total_cnt++; if (bsy[0] !== 1'b0) $display("FAIL t5_rst_busy got %b want 0", bsy[0]);   else pass_cnt++;
    total_cnt++; if (rdy[0] !== 1'b0) $display("FAIL t5_rst_ready got %b want 0", rdy[0]);  else pass_cnt++;
    @(negedge prog_clk); rst = 1'b0;
    words[0] = 8'h3C;
    run(0, 8, 1, -1, 1'b0);
    total_cnt++; if (dn[0] !== 1'b1)  $display("FAIL t5_done got %b want 1", dn[0]);        else pass_cnt++;
    total_cnt++; if (ch0 !== 8'h3C)   $display("FAIL t5_chain got %h want 3c", ch0);        else pass_cnt++;
    total_cnt++; if (crcv[0] !== ref_crc(64'h3C, 8))
      $display("FAIL t5_crc got %h want %h", crcv[0], ref_crc(64'h3C, 8)); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    run(2, 32, 5, -1, 1'b1);
    total_cnt++; if (r_acc !== 4)            $display("FAIL t6_words got %0d want 4", r_acc);           else pass_cnt++;
    total_cnt++; if (r_load !== 32)          $display("FAIL t6_load_shifts got %0d want 32", r_load);   else pass_cnt++;
    total_cnt++; if (r_ver !== 32)           $display("FAIL t6_verify_shifts got %0d want 32", r_ver);  else pass_cnt++;
    total_cnt++; if (dn[2] !== 1'b1)         $display("FAIL t6_done got %b want 1", dn[2]);             else pass_cnt++;
    total_cnt++; if (ch2 !== 32'h11223344)   $display("FAIL t6_chain got %h want 11223344", ch2);       else pass_cnt++;
    total_cnt++; if (crcv[2] !== ref_crc(64'h11223344, 32))
      $display("FAIL t6_crc got %h want %h", crcv[2], ref_crc(64'h11223344, 32)); else pass_cnt++;
    total_cnt++; if (rdy[2] !== 1'b0)        $display("FAIL t6_ready_after got %b want 0", rdy[2]);     else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_word();
    test_partial_word();
    test_stall();
    test_verify_error();
    test_rst_mid_load();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
